sync_delay: RTL and testbench

//  Consumes auto-sync results (as_done/as_timeout/sync_time) and derives the start-trigger delay.

---
 rtl/sync_delay_pkg.sv | 23 ++
 rtl/sync_delay_counter.sv | 42 ++++
 rtl/sync_delay.sv | 222 ++++++++++++++++++++++
 tb/tb_sync_delay.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_delay_pkg.sv
// Shared definitions for the auto-sync trigger delay block.
// Holds FSM state encodings, default widths and sync_time field offsets.
// No logic; imported by sync_delay and its counter.
package sync_delay_pkg;

    // Default widths; TIME_BITS must match the upstream sync_timer stage
    localparam int TIME_BITS_DEF  = 8;
    localparam int DELAY_BITS_DEF = 12;

    // Field index within sync_time = {t1_PS, t0_PS, t1, t0}
    localparam int FLD_T0    = 0;
    localparam int FLD_T1    = 1;
    localparam int FLD_T0_PS = 2;
    localparam int FLD_T1_PS = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC1 = 2'd1,
        ST_CALC2 = 2'd2,
        ST_COUNT = 2'd3
    } state_t;

endpackage

// File: rtl/sync_delay_counter.sv
// Purpose: loadable down-counter that times out the trigger delay.
// Latency: o_done is a registered pulse in the cycle after the count reaches 1.
// Backpressure: none; load has priority over enable.
module delay_counter #(
    parameter int DELAY_BITS = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [DELAY_BITS-1:0] i_val,
    input  logic                  i_en,
    output logic                  o_last,
    output logic                  o_done
);

    logic [DELAY_BITS-1:0] r_cnt;
    logic                  r_done;

    assign o_last = (r_cnt == DELAY_BITS'(1));
    assign o_done = r_done;

    // Count register: load wins, otherwise decrement while enabled and non-zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - DELAY_BITS'(1);
        end
    end

    // Done pulse: one cycle, raised as the last enabled count is consumed
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= i_en && !i_load && o_last;
        end
    end

endmodule

// File: rtl/sync_delay.sv
// Purpose: derive start-trigger delay from auto-sync results and delay trg_in edges by it
//          (optional SYNC_DELAY_AVG_EN averages t0 and t0_PS for the round-trip time).
// Latency: as_done -> delay_value 2 cycles; trigger edge -> trg_out max(delay,1) cycles. No backpressure.
module sync_delay
    import sync_delay_pkg::*;
#(
    parameter int TIME_BITS  = TIME_BITS_DEF,
    parameter int DELAY_BITS = DELAY_BITS_DEF
) (
    input  logic                   clock_det,
    input  logic                   reset_n_det,
    input  logic                   as_prim,
    input  logic                   as_done,
    input  logic                   as_timeout,
    input  logic [4*TIME_BITS-1:0] sync_time,
    input  logic [DELAY_BITS-1:0]  delay_offset,
    input  logic                   trg_in,
    output logic                   trg_out,
    output logic [DELAY_BITS-1:0]  delay_value,
    output logic                   delay_valid,
    output logic                   delay_err,
    output logic                   trg_lost,
    output logic                   busy
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_trg_ff;
    logic                  w_edge;

    // Latched measurement
    logic                  r_prim;
    logic                  r_tmo;
    logic [TIME_BITS-1:0]  r_t0;
`ifdef SYNC_DELAY_AVG_EN
    logic [TIME_BITS-1:0]  r_t0ps;
    logic [TIME_BITS:0]    w_avg;
`endif
    logic [DELAY_BITS-1:0] r_off;
    logic                  r_pend;

    logic [DELAY_BITS:0]   w_rt;
    logic [DELAY_BITS:0]   w_sum;
    logic [DELAY_BITS:0]   r_sum;
    logic [DELAY_BITS-1:0] r_delay;
    logic                  r_valid;
    logic                  r_err;
    logic                  r_lost;

    // FSM control strobes
    logic                  w_latch;
    logic                  w_calc;
    logic                  w_apply;
    logic                  w_load;
    logic                  w_lost;
    logic                  w_pend_set;
    logic                  w_pend_clr;
    logic [DELAY_BITS-1:0] w_load_val;
    logic                  w_cnt_en;
    logic                  w_last;
    logic                  w_done;

    assign w_edge      = trg_in && !r_trg_ff;
    // A zero delay still costs one cycle, so it is counted as one
    assign w_load_val  = (r_delay == '0) ? DELAY_BITS'(1) : r_delay;
    assign w_cnt_en    = (r_state == ST_COUNT);

    assign trg_out     = w_done;
    assign delay_value = r_delay;
    assign delay_valid = r_valid;
    assign delay_err   = r_err;
    assign trg_lost    = r_lost;
    assign busy        = (r_state != ST_IDLE);

    // Trigger edge-detect flop
    always_ff @(posedge clock_det or negedge reset_n_det) begin
        if (!reset_n_det) begin
            r_trg_ff <= 1'b0;
        end else begin
            r_trg_ff <= trg_in;
        end
    end

    // State register
    always_ff @(posedge clock_det or negedge reset_n_det) begin
        if (!reset_n_det) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_calc      = 1'b0;
        w_apply     = 1'b0;
        w_load      = 1'b0;
        w_lost      = 1'b0;
        w_pend_set  = 1'b0;
        w_pend_clr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (as_done) begin
                    // Measurement wins over a coincident trigger
                    w_latch     = 1'b1;
                    w_lost      = w_edge;
                    w_state_nxt = ST_CALC1;
                end else if (w_edge) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_COUNT;
                end
            end
            ST_CALC1: begin
                w_calc      = 1'b1;
                w_lost      = w_edge;
                w_state_nxt = ST_CALC2;
            end
            ST_CALC2: begin
                w_apply     = 1'b1;
                w_lost      = w_edge;
                w_state_nxt = ST_IDLE;
            end
            ST_COUNT: begin
                // Late results are parked and applied once the running count ends
                w_latch = as_done;
                w_lost  = w_edge;
                if (w_last) begin
                    w_pend_clr  = 1'b1;
                    w_state_nxt = (r_pend || as_done) ? ST_CALC1 : ST_IDLE;
                end else begin
                    w_pend_set = as_done;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture measurement inputs on as_done
    always_ff @(posedge clock_det or negedge reset_n_det) begin
        if (!reset_n_det) begin
            r_prim <= 1'b0;
            r_tmo  <= 1'b0;
            r_t0   <= '0;
`ifdef SYNC_DELAY_AVG_EN
            r_t0ps <= '0;
`endif
            r_off  <= '0;
        end else if (w_latch) begin
            r_prim <= as_prim;
            r_tmo  <= as_timeout;
            r_t0   <= sync_time[FLD_T0*TIME_BITS +: TIME_BITS];
`ifdef SYNC_DELAY_AVG_EN
            r_t0ps <= sync_time[FLD_T0_PS*TIME_BITS +: TIME_BITS];
`endif
            r_off  <= delay_offset;
        end
    end

    // Pending-measurement flag for as_done seen while counting
    always_ff @(posedge clock_det or negedge reset_n_det) begin
        if (!reset_n_det) begin
            r_pend <= 1'b0;
        end else if (w_pend_clr) begin
            r_pend <= 1'b0;
        end else if (w_pend_set) begin
            r_pend <= 1'b1;
        end
    end

    // Round-trip time, one extra bit so the sum can flag overflow
`ifdef SYNC_DELAY_AVG_EN
    assign w_avg = ({1'b0, r_t0} + {1'b0, r_t0ps} + (TIME_BITS+1)'(1)) >> 1;
    assign w_rt  = (DELAY_BITS+1)'(w_avg);
`else
    assign w_rt  = (DELAY_BITS+1)'(r_t0);
`endif
    assign w_sum = (r_prim && !r_tmo) ? ((w_rt >> 1) + (DELAY_BITS+1)'(r_off))
                                      : (DELAY_BITS+1)'(r_off);

    // CALC1 sum register, CALC2 saturating apply
    always_ff @(posedge clock_det or negedge reset_n_det) begin
        if (!reset_n_det) begin
            r_sum   <= '0;
            r_delay <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_calc) begin
                r_sum <= w_sum;
            end
            if (w_apply) begin
                r_delay <= r_sum[DELAY_BITS] ? '1 : r_sum[DELAY_BITS-1:0];
                r_valid <= 1'b1;
                r_err   <= r_tmo;
            end
        end
    end

    // Sticky lost-trigger flag
    always_ff @(posedge clock_det or negedge reset_n_det) begin
        if (!reset_n_det) begin
            r_lost <= 1'b0;
        end else if (w_lost) begin
            r_lost <= 1'b1;
        end
    end

    delay_counter #(
        .DELAY_BITS (DELAY_BITS)
    ) u_cnt (
        .i_clk   (clock_det),
        .i_rst_n (reset_n_det),
        .i_load  (w_load),
        .i_val   (w_load_val),
        .i_en    (w_cnt_en),
        .o_last  (w_last),
        .o_done  (w_done)
    );

endmodule

// File: tb/tb_sync_delay.sv
// Directed bench for sync_delay: delay calculation, saturation, trigger timing,
// lost-trigger handling, pending results and asynchronous reset.
module tb_sync_delay;

    localparam int TB = 8;
    localparam int DB = 12;

    logic          clock_det = 1'b0;
    logic          reset_n_det;
    logic          as_prim;
    logic          as_done;
    logic          as_timeout;
    logic [4*TB-1:0] sync_time;
    logic [DB-1:0] delay_offset;
    logic          trg_in;
    logic          trg_out;
    logic [DB-1:0] delay_value;
    logic          delay_valid;
    logic          delay_err;
    logic          trg_lost;
    logic          busy;

    int n_pass  = 0;
    int n_total = 0;
    int n_pulse = 0;

    sync_delay #(.TIME_BITS(TB), .DELAY_BITS(DB)) dut (
        .clock_det    (clock_det),
        .reset_n_det  (reset_n_det),
        .as_prim      (as_prim),
        .as_done      (as_done),
        .as_timeout   (as_timeout),
        .sync_time    (sync_time),
        .delay_offset (delay_offset),
        .trg_in       (trg_in),
        .trg_out      (trg_out),
        .delay_value  (delay_value),
        .delay_valid  (delay_valid),
        .delay_err    (delay_err),
        .trg_lost     (trg_lost),
        .busy         (busy)
    );

    always #5 clock_det = ~clock_det;

    // Count every trg_out cycle, sampled mid-cycle
    always @(negedge clock_det) begin
        if (trg_out === 1'b1) n_pulse++;
    end

    task automatic tick();
        @(posedge clock_det);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Present a measurement for one cycle, then wait for it to be applied
    task automatic do_sync(input logic prim, input logic tmo, input int t0,
                           input int t0ps, input int off);
        as_prim      = prim;
        as_timeout   = tmo;
        sync_time    = {8'd77, 8'(t0ps), 8'd99, 8'(t0)};
        delay_offset = DB'(off);
        as_done      = 1'b1;
        tick();
        as_done      = 1'b0;
        as_timeout   = 1'b0;
        tick();
        tick();
    endtask

    // Cycles from the edge-sampling clock to trg_out, bounded
    task automatic wait_trg(input int start, output int n);
        n = start;
        while (trg_out !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int p0;
        int exp_avg;

        reset_n_det  = 1'b0;
        as_prim      = 1'b0;
        as_done      = 1'b0;
        as_timeout   = 1'b0;
        sync_time    = '0;
        delay_offset = '0;
        trg_in       = 1'b0;
        repeat (3) tick();
        chk("rst_trg_out", trg_out, 0);
        chk("rst_delay_value", delay_value, 0);
        chk("rst_valid", delay_valid, 0);
        chk("rst_busy", busy, 0);
        reset_n_det = 1'b1;
        tick();

        // 1: primary, t0=40, offset 10 -> 30
        as_prim = 1'b1; sync_time = {8'd77, 8'd0, 8'd99, 8'd40};
        delay_offset = 12'd10; as_done = 1'b1;
        tick();
        as_done = 1'b0;
        chk("t1_busy_calc1", busy, 1);
        tick();
        chk("t1_value_1cyc", delay_value, 0);
        tick();
        chk("t1_value_2cyc", delay_value, 30);
        chk("t1_valid", delay_valid, 1);
        chk("t1_err", delay_err, 0);
        chk("t1_busy_idle", busy, 0);
        trg_in = 1'b1;
        tick();
        chk("t1_busy_count", busy, 1);
        wait_trg(0, n);
        chk("t1_trg_latency", n, 30);
        tick();
        chk("t1_trg_one_cycle", trg_out, 0);
        chk("t1_busy_after", busy, 0);
        trg_in = 1'b0;

        // 2: secondary ignores cable delay
        do_sync(1'b0, 1'b0, 40, 0, 7);
        chk("t2_value", delay_value, 7);
        chk("t2_err", delay_err, 0);
        chk("t2_valid", delay_valid, 1);

        // 3: primary timeout falls back to offset
        do_sync(1'b1, 1'b1, 40, 0, 5);
        chk("t3_value", delay_value, 5);
        chk("t3_err", delay_err, 1);

        // 4: saturation, then zero delay
        do_sync(1'b1, 1'b0, 254, 0, 4090);
        chk("t4_saturate", delay_value, 4095);
        chk("t4_err_clear", delay_err, 0);
        do_sync(1'b0, 1'b0, 0, 0, 0);
        chk("t4_zero_value", delay_value, 0);
        trg_in = 1'b1;
        tick();
        wait_trg(0, n);
        chk("t4_zero_latency", n, 1);
        trg_in = 1'b0;
        tick();
        chk("t4_no_lost", trg_lost, 0);

        // 5: as_done with coincident edge, edge during COUNT, pending result
        p0 = n_pulse;
        as_prim = 1'b0; delay_offset = 12'd20; as_done = 1'b1; trg_in = 1'b1;
        tick();
        as_done = 1'b0;
        chk("t5_lost_coincident", trg_lost, 1);
        chk("t5_busy_calc", busy, 1);
        tick();
        tick();
        chk("t5_value20", delay_value, 20);
        chk("t5_dropped_trigger", n_pulse - p0, 0);
        trg_in = 1'b0;
        tick();
        trg_in = 1'b1;
        tick();                            // edge sampled here
        repeat (4) tick();
        trg_in = 1'b0;
        tick();
        trg_in = 1'b1;
        tick();                            // second edge, ignored while counting
        delay_offset = 12'd3; as_done = 1'b1;
        tick();
        as_done = 1'b0;
        wait_trg(7, n);
        chk("t5_latency_unmodified", n, 20);
        chk("t5_value_before_pend", delay_value, 20);
        tick();
        tick();
        chk("t5_pending_applied", delay_value, 3);
        repeat (5) tick();
        chk("t5_single_pulse", n_pulse - p0, 1);
        chk("t5_lost_sticky", trg_lost, 1);
        trg_in = 1'b0;

        // 6: reset in the middle of a count
        do_sync(1'b0, 1'b0, 0, 0, 50);
        chk("t6_value50", delay_value, 50);
        trg_in = 1'b1;
        tick();
        repeat (10) tick();
        reset_n_det = 1'b0;
        #1;
        chk("t6_rst_trg_out", trg_out, 0);
        chk("t6_rst_value", delay_value, 0);
        chk("t6_rst_valid", delay_valid, 0);
        chk("t6_rst_err", delay_err, 0);
        chk("t6_rst_lost", trg_lost, 0);
        chk("t6_rst_busy", busy, 0);
        trg_in = 1'b0;
        p0 = n_pulse;
        repeat (60) tick();
        reset_n_det = 1'b1;
        repeat (5) tick();
        chk("t6_no_pulse", n_pulse - p0, 0);
        chk("t6_idle_after", busy, 0);

        // Averaging path: t0=40, t0_PS=43 -> rt 42 -> 21; without it rt=40 -> 20
`ifdef SYNC_DELAY_AVG_EN
        exp_avg = 21;
`else
        exp_avg = 20;
`endif
        do_sync(1'b1, 1'b0, 40, 43, 0);
        chk("t6_avg_value", delay_value, exp_avg);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
